// File: rtl/filt_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the multi-channel MAC filters.
package filt_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } sat_res_t;

  function automatic int coeff_size(input int n, input int symm);
    return (symm != 0) ? (n + 1) / 2 : n;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int cs);
    return dw + 1 + cw + $clog2(cs);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clip x into the signed w-bit range; w must not exceed 63.
  function automatic sat_res_t sat_to_width(input logic signed [63:0] x, input int w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           r;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    r.sat = (x > max_v) || (x < min_v);
    if (x > max_v)      r.value = max_v;
    else if (x < min_v) r.value = min_v;
    else                r.value = x;
    return r;
  endfunction

endpackage

// File: rtl/filt_sat_round.sv
// Combinational output stage: arithmetic shift, optional round-half-up, signed saturation.
// Rounding is built only when FILT_MAC_MC_ROUND_EN is defined.
module filt_sat_round
  import filt_pkg::*;
#(
  parameter int gp_acc_width = 25,
  parameter int gp_oup_shift = 0,
  parameter int gp_oup_width = 24
) (
  input  logic signed [gp_acc_width-1:0] i_acc,
  output logic signed [gp_oup_width-1:0] o_data,
  output logic                           o_sat
);

`ifdef FILT_MAC_MC_ROUND_EN
  localparam logic signed [63:0] c_half =
    (gp_oup_shift > 0) ? (64'sd1 <<< (gp_oup_shift - 1)) : 64'sd0;
`endif

  logic signed [63:0] acc_ext;
  logic signed [63:0] shifted;
  sat_res_t           res;
  logic [63:0]        res_unused;

  always_comb begin
    acc_ext = 64'(i_acc);
`ifdef FILT_MAC_MC_ROUND_EN
    acc_ext = acc_ext + c_half;
`endif
    shifted = acc_ext >>> gp_oup_shift;
    res     = sat_to_width(shifted, gp_oup_width);
  end

  // Upper bits of the clipped value are pure sign extension.
  assign res_unused = res.value;
  assign o_data     = res.value[gp_oup_width-1:0];
  assign o_sat      = res.sat;

endmodule

// File: rtl/filt_mac_mc.sv
// Multi-channel time-multiplexed serial-MAC FIR with shared runtime coefficients.
// Build option: FILT_MAC_MC_ROUND_EN enables round-half-up before the output shift.
module filt_mac_mc
  import filt_pkg::*;
#(
  parameter int gp_data_width   = 8,
  parameter int gp_coeff_width  = 12,
  parameter int gp_coeff_length = 17,
  parameter int gp_num_ch       = 2,
  parameter int gp_symm         = 1,
  parameter int gp_oup_shift    = 0,
  parameter int gp_oup_width    = 24
) (
  input  logic                                                          i_clk,
  input  logic                                                          i_rst_an,
  input  logic                                                          i_valid,
  output logic                                                          o_ready,
  input  logic [idx_width(gp_num_ch)-1:0]                               i_ch,
  input  logic signed [gp_data_width-1:0]                               i_data,
  input  logic                                                          i_coeff_we,
  input  logic [idx_width(coeff_size(gp_coeff_length, gp_symm))-1:0]   i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0]                              i_coeff_data,
  output logic                                                          o_valid,
  output logic [idx_width(gp_num_ch)-1:0]                               o_ch,
  output logic signed [gp_oup_width-1:0]                                o_data,
  output logic                                                          o_sat
);

  localparam int c_coeff_size = coeff_size(gp_coeff_length, gp_symm);
  localparam int c_acc_width  = acc_width(gp_data_width, gp_coeff_width, c_coeff_size);
  localparam int c_ch_w       = idx_width(gp_num_ch);
  localparam int c_addr_w     = idx_width(c_coeff_size);
  localparam int c_tap_w      = idx_width(gp_coeff_length);
  localparam int c_a_w        = gp_data_width + 1;
  localparam int c_p_w        = c_a_w + gp_coeff_width;
  localparam logic [c_addr_w-1:0] c_last_k = c_addr_w'(c_coeff_size - 1);

  logic [1:0]                        state_q, state_d;
  logic [c_addr_w-1:0]               k_q, k_d;
  logic [c_ch_w-1:0]                 ch_q, ch_d;
  logic signed [c_acc_width-1:0]     acc_q, acc_d;
  logic signed [gp_data_width-1:0]   dl_q [gp_num_ch][gp_coeff_length];
  logic signed [gp_data_width-1:0]   dl_d [gp_num_ch][gp_coeff_length];
  logic signed [gp_coeff_width-1:0]  coeff_q [c_coeff_size];
  logic signed [gp_coeff_width-1:0]  coeff_d [c_coeff_size];
  logic                              o_valid_q, o_valid_d;
  logic [c_ch_w-1:0]                 o_ch_q, o_ch_d;
  logic signed [gp_oup_width-1:0]    o_data_q, o_data_d;
  logic                              o_sat_q, o_sat_d;

  logic [c_tap_w-1:0]                tap_k, tap_m;
  logic                              is_mid;
  logic signed [c_a_w-1:0]           a_sum;
  logic signed [c_p_w-1:0]           prod;
  logic signed [c_acc_width-1:0]     acc_sum;
  logic signed [gp_oup_width-1:0]    sat_data;
  logic                              sat_flag;
  logic                              hs;

  assign o_ready = (state_q == S_IDLE);
  assign hs      = i_valid && o_ready;

  // Datapath kept in its own process so the output stage sees acc_sum without a false loop.
  always_comb begin
    tap_k  = c_tap_w'(k_q);
    tap_m  = c_tap_w'(gp_coeff_length - 1) - tap_k;
    is_mid = (gp_coeff_length % 2 == 1) && (k_q == c_last_k);
    a_sum  = c_a_w'(dl_q[ch_q][tap_k]);
    if (gp_symm != 0 && !is_mid) a_sum = a_sum + c_a_w'(dl_q[ch_q][tap_m]);
    prod    = c_p_w'(a_sum) * c_p_w'(coeff_q[k_q]);
    acc_sum = acc_q + c_acc_width'(prod);
  end

  filt_sat_round #(
    .gp_acc_width (c_acc_width),
    .gp_oup_shift (gp_oup_shift),
    .gp_oup_width (gp_oup_width)
  ) u_sat_round (
    .i_acc  (acc_sum),
    .o_data (sat_data),
    .o_sat  (sat_flag)
  );

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    k_d       = k_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    dl_d      = dl_q;
    coeff_d   = coeff_q;
    o_valid_d = 1'b0;
    o_ch_d    = o_ch_q;
    o_data_d  = o_data_q;
    o_sat_d   = o_sat_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (int'(i_ch) < gp_num_ch) begin
            for (int c = 0; c < gp_num_ch; c++) begin
              if (c_ch_w'(c) == i_ch) begin
                for (int t = gp_coeff_length - 1; t > 0; t--) dl_d[c][t] = dl_q[c][t-1];
                dl_d[c][0] = i_data;
              end
            end
            ch_d    = i_ch;
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end
        end else if (i_coeff_we && int'(i_coeff_addr) < c_coeff_size) begin
          coeff_d[i_coeff_addr] = i_coeff_data;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + c_addr_w'(1);
        // Outputs load on the final product so o_valid lands in the OUT cycle.
        if (k_q == c_last_k) begin
          state_d   = S_OUT;
          o_valid_d = 1'b1;
          o_ch_d    = ch_q;
          o_data_d  = sat_data;
          o_sat_d   = sat_flag;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: delay lines and coefficients are reset too, so an aborted run leaves no stale history.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_ch_q    <= '0;
      o_data_q  <= '0;
      o_sat_q   <= 1'b0;
      for (int c = 0; c < gp_num_ch; c++)
        for (int t = 0; t < gp_coeff_length; t++) dl_q[c][t] <= '0;
      for (int i = 0; i < c_coeff_size; i++) coeff_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q   <= state_d;
      k_q       <= k_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      o_valid_q <= o_valid_d;
      o_ch_q    <= o_ch_d;
      o_data_q  <= o_data_d;
      o_sat_q   <= o_sat_d;
      dl_q      <= dl_d;
      coeff_q   <= coeff_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_ch    = o_ch_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;

endmodule

// File: doc/filt_mac_mc.md
Name: filt_mac_mc

Overview:
- Multi-channel, time-multiplexed serial-MAC FIR filter.
- Keeps one delay line per channel and shares one multiplier/accumulator across all channels.
- Coefficients are runtime-programmable and shared by all channels.
- Sits between a decimator/CIC stage and downstream DSP. Input uses a valid/ready handshake; output is a single-cycle valid strobe with a channel tag.

Parameters:
- gp_data_width, 8, input sample width (signed).
- gp_coeff_width, 12, coefficient width (signed).
- gp_coeff_length, 17, number of taps N.
- gp_num_ch, 2, number of independent channels (≥1).
- gp_symm, 1, 1 = symmetric-coefficient folding; 0 = generic FIR.
- gp_oup_shift, 0, arithmetic right shift applied to the accumulator before output.
- gp_oup_width, 24, output width (signed, saturated).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_an  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept a sample.
- i_ch  in  max(1,clog2(gp_num_ch))  channel of the input sample.
- i_data  in  gp_data_width  signed input sample.
- i_coeff_we  in  1  coefficient write strobe.
- i_coeff_addr  in  clog2(c_coeff_size)  coefficient index.
- i_coeff_data  in  gp_coeff_width  signed coefficient value.
- o_valid  out  1  one-cycle result strobe.
- o_ch  out  max(1,clog2(gp_num_ch))  channel of o_data.
- o_data  out  gp_oup_width  signed filtered sample.
- o_sat  out  1  saturation occurred on the current o_data.

Behaviour:
- Reset values: o_ready=1, o_valid=0, o_ch=0, o_data=0, o_sat=0. All delay lines, coefficients and the accumulator are 0. FSM is in IDLE.
- Derived constants:
  - c_coeff_size = gp_symm ? ceil(N/2) : N.
  - c_acc_width = gp_data_width+1+gp_coeff_width+clog2(c_coeff_size).
- FSM IDLE:
  - o_ready=1.
  - On i_valid&&o_ready with i_ch<gp_num_ch: shift i_data into delay line[i_ch] (newest at tap 0), latch the channel, clear the accumulator, go to MAC.
  - If i_ch≥gp_num_ch: the sample is dropped and the FSM stays in IDLE.
- FSM MAC:
  - o_ready=0; counter k runs 0..c_coeff_size-1, one product per cycle.
  - acc += A(k)*coeff[k].
  - Symmetric mode: A(k) = dl[k]+dl[N-1-k], sign-extended one bit. For odd N, the middle tap (k=c_coeff_size-1) uses dl[k] only.
  - Generic mode: A(k) = dl[k].
  - After the last k, go to OUT.
- FSM OUT (one cycle): register o_data/o_ch/o_sat, pulse o_valid=1, return to IDLE. o_ready=0 during OUT.
- Latency: handshake at cycle 0; o_valid at cycle c_coeff_size+1. Maximum throughput is one sample per c_coeff_size+2 cycles, across all channels.
- Output arithmetic:
  - y = acc >>> gp_oup_shift (truncation toward −∞).
  - y is saturated to the signed gp_oup_width range; o_sat=1 when clipping occurs.
  - o_data/o_ch/o_sat hold their values until the next OUT.
- Coefficient writes:
  - Accepted only in IDLE, and only on a cycle with no input handshake. They are ignored in any other state or on a handshake cycle.
  - i_coeff_addr ≥ c_coeff_size is ignored.
  - A write takes effect from the next sample.
- Reset asserted mid-MAC: abort immediately. No o_valid is produced. All state returns to the reset values, including delay lines and coefficients.
- Delay lines of channels other than the latched one are never modified.

Optional Feature:
- Macro FILT_MAC_MC_ROUND_EN.
- When defined and gp_oup_shift>0: add 2^(gp_oup_shift-1) to acc before the shift (round half up), then saturate.
- When undefined: plain truncation; no rounding adder is synthesised.

Decomposition:
- Shared package filt_pkg holds:
  - the c_coeff_size / c_acc_width computation functions;
  - the FSM state encoding (IDLE, MAC, OUT);
  - the saturate-to-width function.
- Sub-module filt_sat_round: shift, optional round and saturate on the accumulator. It is combinational, instantiated once, and also reusable by other filters.

Test Plan:
- Impulse response: program coeff[0..8] = 1..9, N=17, symm. Feed impulse 1 then 16 zeros on ch0 → o_data sequence 1,2,…,9,8,…,1, then 0. o_valid arrives 10 cycles after each handshake.
- Channel isolation: gp_num_ch=2. Feed ch0=100 and ch1=−50 interleaved with coeff[0]=1, others 0 → ch0 outputs 100,0,… and ch1 outputs −50,0,…. No cross-talk; o_ch matches the input channel.
- Saturation: gp_oup_width=8. All coeff = 2047, inputs = 127 → o_data=127, o_sat=1. Inputs = −128 → o_data=−128, o_sat=1.
- Handshake and coefficient lockout:
  - Hold i_valid high continuously → exactly one acceptance per 11 cycles; o_ready is low during MAC/OUT.
  - A coefficient write issued during MAC is ignored (the next result is unchanged).
- Reset mid-MAC: assert i_rst_an=0 at MAC cycle 4 → o_valid is never raised and all outputs read 0. The next impulse after release yields all-zero output (coefficients cleared).
- Rounding (FILT_MAC_MC_ROUND_EN, gp_oup_shift=2): acc=6 → o_data=2. Without the macro → o_data=1.
